// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU decode/issue stage.
// Holds the default parameter values, the ALU opcode map, the I-type class codes,
// the instruction class enum, the issue FSM state enum and opcode classification helpers.
package alu_issue_ctrl_pkg;

  localparam int DATA_W_DEF       = 8;
  localparam int NUM_REGS_DEF     = 16;
  localparam int MAX_INFLIGHT_DEF = 3;
  localparam int BR_SHADOW_DEF    = 1;
  localparam int SHADOW_W         = 4;

  // R-type opcodes (instr[8] = 0)
  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_XOR = 5'b00100;
  localparam logic [4:0] OP_SHL = 5'b00101;
  localparam logic [4:0] OP_SHR = 5'b00110;
  localparam logic [4:0] OP_MV  = 5'b00111;

  // I-type class codes (opcode bits [4:2])
  localparam logic [2:0] CLS_ADDI = 3'b100;
  localparam logic [2:0] CLS_BNE  = 3'b101;
  localparam logic [2:0] CLS_BEZ  = 3'b110;
  localparam logic [2:0] CLS_LDI  = 3'b111;

  typedef enum logic [1:0] {OP_R, OP_IMM, OP_BR} op_class_e;

  typedef enum logic {ST_RUN, ST_SQUASH} issue_state_e;

  function automatic op_class_e op_class(input logic [4:0] op);
    if (!op[4]) return OP_R;
    if ((op[4:2] == CLS_BNE) || (op[4:2] == CLS_BEZ)) return OP_BR;
    return OP_IMM;
  endfunction

  // Every non-branch op targets R0 and therefore counts as an in-flight producer.
  function automatic logic is_r0_writer(input logic [4:0] op);
    return op_class(op) != OP_BR;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// Register file for the issue stage.
// NUM_REGS x DATA_W storage, two asynchronous read ports, one synchronous write port.
// A write in the same cycle as a read of the same index is forwarded to the read data.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (clears all registers)
//   i_we/i_waddr/i_wdata  write port
//   i_raddrA/o_rdataA     read port A
//   i_raddrB/o_rdataB     read port B
module alu_issue_ctrl_regfile #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddrA,
  output logic [DATA_W-1:0] o_rdataA,
  input  logic [ADDR_W-1:0] i_raddrB,
  output logic [DATA_W-1:0] o_rdataB
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Write-through so a writeback landing this cycle is seen by a same-cycle decode.
  assign o_rdataA = (i_we && (i_waddr == i_raddrA)) ? i_wdata : r_mem[i_raddrA];
  assign o_rdataB = (i_we && (i_waddr == i_raddrB)) ? i_wdata : r_mem[i_raddrB];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Decode/issue stage feeding a combinational ALU.
// Decodes 9-bit instructions into OP/inOne/inTwo, holds them in a one-entry issue
// register, interlocks on outstanding R0 producers and drops wrong-path instructions
// after a taken branch.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   i_in_valid/i_in_instr/o_in_ready   fetch handshake
//   o_alu_valid/i_alu_ready            ALU handshake
//   o_alu_op/o_alu_in_one/o_alu_in_two issued op and operands
//   i_alu_branch_pass                  ALU branch compare result for the issuing branch
//   i_wb_en/i_wb_addr/i_wb_data        register writeback
//   o_redirect_valid/o_redirect_off    one-cycle fetch redirect with sign-extended offset
//   o_err_underflow                    sticky: R0 writeback with nothing in flight
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int NUM_REGS     = NUM_REGS_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int BR_SHADOW    = BR_SHADOW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_in_valid,
  input  logic [8:0]        i_in_instr,
  output logic              o_in_ready,
  output logic              o_alu_valid,
  input  logic              i_alu_ready,
  output logic [4:0]        o_alu_op,
  output logic [DATA_W-1:0] o_alu_in_one,
  output logic [DATA_W-1:0] o_alu_in_two,
  input  logic              i_alu_branch_pass,
  input  logic              i_wb_en,
  input  logic [3:0]        i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic              o_redirect_valid,
  output logic [DATA_W-1:0] o_redirect_off,
  output logic              o_err_underflow
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic [DATA_W-1:0] w_rdR0, w_rdRs, w_imm;
  logic              w_wbR0, w_interlock, w_atCap, w_runReady;
  logic              w_accept, w_issueLoad, w_handshake, w_takenBr;
  logic              w_incCnt, w_decCnt;

  logic [CNT_W-1:0]    r_cnt;
  logic                r_aluValid;
  logic [4:0]          r_aluOp;
  logic [DATA_W-1:0]   r_aluInOne, r_aluInTwo;
  logic                r_redirectValid;
  logic [DATA_W-1:0]   r_redirectOff;
  logic                r_errUnderflow;

  issue_state_e        r_state, w_stateNext;
  logic [SHADOW_W-1:0] r_shadowCnt, w_shadowNext;

  alu_issue_ctrl_regfile #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (4)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (i_wb_en),
    .i_waddr (i_wb_addr),
    .i_wdata (i_wb_data),
    .i_raddrA(4'd0),
    .o_rdataA(w_rdR0),
    .i_raddrB(i_in_instr[3:0]),
    .o_rdataB(w_rdRs)
  );

  assign w_imm = {{(DATA_W-6){i_in_instr[5]}}, i_in_instr[5:0]};

  // A lone outstanding R0 producer may be bypassed when its writeback arrives this
  // cycle; the regfile write-through then supplies the fresh R0 value.
  assign w_wbR0      = i_wb_en && (i_wb_addr == 4'd0);
  assign w_interlock = (r_cnt != '0) && !((r_cnt == CNT_W'(1)) && w_wbR0);
  assign w_atCap     = (r_cnt == CNT_W'(MAX_INFLIGHT));
  assign w_runReady  = (!r_aluValid || i_alu_ready) && !w_interlock && !w_atCap;

  assign w_accept    = i_in_valid && o_in_ready;
  assign w_handshake = r_aluValid && i_alu_ready;
  assign w_takenBr   = w_handshake && (op_class(r_aluOp) == OP_BR) && i_alu_branch_pass;
  assign w_incCnt    = w_handshake && is_r0_writer(r_aluOp);
  assign w_decCnt    = w_wbR0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_shadowCnt <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_shadowCnt <= w_shadowNext;
    end
  end

  // A taken branch (re)arms the shadow; each accept while squashing burns one slot.
  always_comb begin
    w_stateNext  = r_state;
    w_shadowNext = r_shadowCnt;
    if (w_takenBr && (BR_SHADOW > 0)) begin
      w_stateNext  = ST_SQUASH;
      w_shadowNext = SHADOW_W'(BR_SHADOW);
    end else if ((r_state == ST_SQUASH) && w_accept) begin
      w_shadowNext = r_shadowCnt - 1'b1;
      if (r_shadowCnt == SHADOW_W'(1)) w_stateNext = ST_RUN;
    end
  end

  // While squashing, fetch is drained unconditionally and nothing reaches the issue register.
  always_comb begin
    o_in_ready  = w_runReady;
    w_issueLoad = 1'b0;
    if (r_state == ST_SQUASH) begin
      o_in_ready = 1'b1;
    end else begin
      w_issueLoad = w_accept;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aluValid <= 1'b0;
      r_aluOp    <= '0;
      r_aluInOne <= '0;
      r_aluInTwo <= '0;
    end else if (w_issueLoad) begin
      r_aluValid <= 1'b1;
      r_aluOp    <= i_in_instr[8:4];
      r_aluInOne <= w_rdR0;
      r_aluInTwo <= i_in_instr[8] ? w_imm : w_rdRs;
    end else if (w_handshake) begin
      r_aluValid <= 1'b0;
    end
  end

  // Simultaneous issue and writeback of R0 producers cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_errUnderflow <= 1'b0;
    end else if (w_incCnt && !w_decCnt) begin
      if (!w_atCap) r_cnt <= r_cnt + 1'b1;
    end else if (w_decCnt && !w_incCnt) begin
      if (r_cnt == '0) r_errUnderflow <= 1'b1;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

  // Branch operand two is the sign-extended immediate, which doubles as the offset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirectValid <= 1'b0;
      r_redirectOff   <= '0;
    end else begin
      r_redirectValid <= w_takenBr;
      if (w_takenBr) r_redirectOff <= r_aluInTwo;
    end
  end

  assign o_alu_valid      = r_aluValid;
  assign o_alu_op         = r_aluOp;
  assign o_alu_in_one     = r_aluInOne;
  assign o_alu_in_two     = r_aluInTwo;
  assign o_redirect_valid = r_redirectValid;
  assign o_redirect_off   = r_redirectOff;
  assign o_err_underflow  = r_errUnderflow;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, hand-written corner
// sequences and a randomized phase, all shadowed by a cycle-level reference model.
module tb_alu_issue_ctrl;

  localparam int DATA_W       = 8;
  localparam int MAX_INFLIGHT = 3;
  localparam int BR_SHADOW    = 1;

  logic        clk;
  logic        rst_n;
  logic        inValid;
  logic [8:0]  inInstr;
  logic        inReady;
  logic        aluValid;
  logic        aluReady;
  logic [4:0]  aluOp;
  logic [7:0]  aluInOne;
  logic [7:0]  aluInTwo;
  logic        aluBranchPass;
  logic        wbEn;
  logic [3:0]  wbAddr;
  logic [7:0]  wbData;
  logic        redirectValid;
  logic [7:0]  redirectOff;
  logic        errUnderflow;

  int total;
  int bad;

  // Reference model state
  int mRegs [16];
  int mCnt;
  bit mSquash;
  int mShadow;
  bit mValid;
  int mOp, mOne, mTwo;
  bit mRedirV;
  int mRedirOff;
  bit mErr;

  typedef struct {
    logic [8:0] instr;
    bit         writer;
    logic [4:0] expOp;
    logic [7:0] expOne;
    logic [7:0] expTwo;
  } vec_t;

  vec_t vecs [9];

  alu_issue_ctrl #(
    .DATA_W      (DATA_W),
    .NUM_REGS    (16),
    .MAX_INFLIGHT(MAX_INFLIGHT),
    .BR_SHADOW   (BR_SHADOW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_in_valid       (inValid),
    .i_in_instr       (inInstr),
    .o_in_ready       (inReady),
    .o_alu_valid      (aluValid),
    .i_alu_ready      (aluReady),
    .o_alu_op         (aluOp),
    .o_alu_in_one     (aluInOne),
    .o_alu_in_two     (aluInTwo),
    .i_alu_branch_pass(aluBranchPass),
    .i_wb_en          (wbEn),
    .i_wb_addr        (wbAddr),
    .i_wb_data        (wbData),
    .o_redirect_valid (redirectValid),
    .o_redirect_off   (redirectOff),
    .o_err_underflow  (errUnderflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit isBranchOp(input int op);
    return ((op >> 2) == 5) || ((op >> 2) == 6);
  endfunction

  function automatic int modelReadReg(input int a);
    if (wbEn && (int'(wbAddr) == a)) return int'(wbData);
    return mRegs[a];
  endfunction

  function automatic bit modelInReady();
    if (mSquash) return 1'b1;
    if (mValid && !aluReady) return 1'b0;
    if (mCnt >= MAX_INFLIGHT) return 1'b0;
    if (mCnt == 0) return 1'b1;
    return (mCnt == 1) && wbEn && (wbAddr == 4'd0);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mRegs[i] = 0;
    mCnt = 0; mSquash = 0; mShadow = 0;
    mValid = 0; mOp = 0; mOne = 0; mTwo = 0;
    mRedirV = 0; mRedirOff = 0; mErr = 0;
  endtask

  task automatic modelAdvance();
    bit rdy, acc, hs, taken, writer, wbR0;
    int nOne, nTwo, imm;
    rdy    = modelInReady();
    acc    = inValid && rdy;
    hs     = mValid && aluReady;
    taken  = hs && isBranchOp(mOp) && aluBranchPass;
    writer = !isBranchOp(mOp);
    wbR0   = wbEn && (wbAddr == 4'd0);
    nOne   = modelReadReg(0);
    if (inInstr[8]) begin
      imm = int'(inInstr[5:0]);
      if (imm >= 32) imm = imm - 64;
      nTwo = imm & 255;
    end else begin
      nTwo = modelReadReg(int'(inInstr[3:0]));
    end
    mRedirV = taken;
    if (taken) mRedirOff = mTwo;
    if (acc && !mSquash) begin
      mValid = 1; mOp = int'(inInstr[8:4]); mOne = nOne; mTwo = nTwo;
    end else if (hs) begin
      mValid = 0;
    end
    if (hs && writer && !wbR0) begin
      if (mCnt < MAX_INFLIGHT) mCnt++;
    end else if (wbR0 && !(hs && writer)) begin
      if (mCnt == 0) mErr = 1;
      else mCnt--;
    end
    if (wbEn) mRegs[wbAddr] = int'(wbData);
    if (taken && (BR_SHADOW > 0)) begin
      mSquash = 1; mShadow = BR_SHADOW;
    end else if (mSquash && acc) begin
      mShadow--;
      if (mShadow == 0) mSquash = 0;
    end
  endtask

  task automatic checkOutput();
    checkVal("model in_ready", int'(inReady), int'(modelInReady()));
    checkVal("model alu_valid", int'(aluValid), int'(mValid));
    checkVal("model alu_op", int'(aluOp), mOp);
    checkVal("model in_one", int'(aluInOne), mOne);
    checkVal("model in_two", int'(aluInTwo), mTwo);
    checkVal("model redirect_valid", int'(redirectValid), int'(mRedirV));
    checkVal("model redirect_off", int'(redirectOff), mRedirOff);
    checkVal("model err_underflow", int'(errUnderflow), int'(mErr));
  endtask

  task automatic applyStimulus(input bit v, input logic [8:0] instr, input bit rdy,
                               input bit bp, input bit we, input logic [3:0] wa,
                               input logic [7:0] wd);
    inValid = v; inInstr = instr; aluReady = rdy; aluBranchPass = bp;
    wbEn = we; wbAddr = wa; wbData = wd;
  endtask

  // Called just after a falling edge with inputs applied; leaves at the next falling edge.
  task automatic stepCycle();
    #1;
    checkOutput();
    modelAdvance();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{9'h003, 1'b1, 5'h00, 8'h11, 8'h05};
    vecs[1] = '{9'h0F5, 1'b1, 5'h0F, 8'h11, 8'h7F};
    vecs[2] = '{9'h039, 1'b1, 5'h03, 8'h11, 8'h80};
    vecs[3] = '{9'h07F, 1'b1, 5'h07, 8'h11, 8'hC3};
    vecs[4] = '{9'h11F, 1'b1, 5'h11, 8'h11, 8'h1F};
    vecs[5] = '{9'h1E0, 1'b1, 5'h1E, 8'h11, 8'hE0};
    vecs[6] = '{9'h1BF, 1'b0, 5'h1B, 8'h11, 8'hFF};
    vecs[7] = '{9'h15A, 1'b0, 5'h15, 8'h11, 8'h1A};
    vecs[8] = '{9'h00A, 1'b1, 5'h00, 8'h11, 8'h00};

    rst_n = 1'b0;
    applyStimulus(0, 9'h000, 0, 0, 0, 4'd0, 8'h00);
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    checkVal("reset alu_valid", int'(aluValid), 0);
    checkVal("reset redirect_valid", int'(redirectValid), 0);
    checkVal("reset err_underflow", int'(errUnderflow), 0);
    checkVal("reset alu_op", int'(aluOp), 0);
    rst_n = 1'b1;

    // ADDI imm 0 from reset, then the next instruction must stall on R0
    applyStimulus(1, 9'h100, 0, 0, 0, 4'd0, 8'h00);
    #1 checkVal("addi in_ready", int'(inReady), 1);
    stepCycle();
    applyStimulus(0, 9'h000, 1, 0, 0, 4'd0, 8'h00);
    #1;
    checkVal("addi alu_valid", int'(aluValid), 1);
    checkVal("addi op", int'(aluOp), 5'h10);
    checkVal("addi in_one", int'(aluInOne), 0);
    checkVal("addi in_two", int'(aluInTwo), 0);
    stepCycle();
    applyStimulus(1, 9'h003, 0, 0, 0, 4'd0, 8'h00);
    #1 checkVal("addi stall in_ready", int'(inReady), 0);
    stepCycle();
    applyStimulus(0, 9'h000, 0, 0, 0, 4'd0, 8'h00);
    #1 checkVal("stall not accepted", int'(aluValid), 0);
    stepCycle();
    applyStimulus(0, 9'h000, 0, 0, 1, 4'd0, 8'h11);
    stepCycle();
    applyStimulus(0, 9'h000, 0, 0, 1, 4'd3, 8'h05);
    stepCycle();
    applyStimulus(0, 9'h000, 0, 0, 1, 4'd5, 8'h7F);
    stepCycle();
    applyStimulus(0, 9'h000, 0, 0, 1, 4'd9, 8'h80);
    stepCycle();
    applyStimulus(0, 9'h000, 0, 0, 1, 4'd15, 8'hC3);
    stepCycle();

    // Decode table
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, vecs[i].instr, 0, 0, 0, 4'd0, 8'h00);
      stepCycle();
      applyStimulus(0, 9'h000, 0, 0, 0, 4'd0, 8'h00);
      #1;
      checkVal($sformatf("vec%0d alu_valid", i), int'(aluValid), 1);
      checkVal($sformatf("vec%0d op", i), int'(aluOp), int'(vecs[i].expOp));
      checkVal($sformatf("vec%0d in_one", i), int'(aluInOne), int'(vecs[i].expOne));
      checkVal($sformatf("vec%0d in_two", i), int'(aluInTwo), int'(vecs[i].expTwo));
      stepCycle();
      applyStimulus(0, 9'h000, 1, 0, 0, 4'd0, 8'h00);
      stepCycle();
      applyStimulus(0, 9'h000, 0, 0, 0, 4'd0, 8'h00);
      #1 checkVal($sformatf("vec%0d in_ready after", i), int'(inReady), vecs[i].writer ? 0 : 1);
      stepCycle();
      if (vecs[i].writer) begin
        applyStimulus(0, 9'h000, 0, 0, 1, 4'd0, 8'h11);
        stepCycle();
      end
    end

    // R0 writeback bypass with one producer in flight
    applyStimulus(1, 9'h105, 0, 0, 0, 4'd0, 8'h00);
    stepCycle();
    applyStimulus(0, 9'h000, 1, 0, 0, 4'd0, 8'h00);
    stepCycle();
    applyStimulus(1, 9'h003, 0, 0, 1, 4'd0, 8'h2A);
    #1 checkVal("bypass in_ready", int'(inReady), 1);
    stepCycle();
    applyStimulus(0, 9'h000, 0, 0, 0, 4'd0, 8'h00);
    #1;
    checkVal("bypass alu_valid", int'(aluValid), 1);
    checkVal("bypass in_one", int'(aluInOne), 8'h2A);
    checkVal("bypass in_two", int'(aluInTwo), 8'h05);
    stepCycle();
    applyStimulus(0, 9'h000, 1, 0, 0, 4'd0, 8'h00);
    stepCycle();
    applyStimulus(0, 9'h000, 0, 0, 0, 4'd0, 8'h00);
    #1 checkVal("bypass count held", int'(inReady), 0);
    stepCycle();
    applyStimulus(0, 9'h000, 0, 0, 1, 4'd0, 8'h11);
    stepCycle();

    // Taken BEZ, offset -2, shadow instruction dropped
    applyStimulus(1, 9'h1BE, 0, 0, 0, 4'd0, 8'h00);
    stepCycle();
    applyStimulus(0, 9'h000, 1, 1, 0, 4'd0, 8'h00);
    stepCycle();
    applyStimulus(1, 9'h105, 0, 0, 0, 4'd0, 8'h00);
    #1;
    checkVal("branch redirect_valid", int'(redirectValid), 1);
    checkVal("branch redirect_off", int'(redirectOff), 8'hFE);
    checkVal("branch squash in_ready", int'(inReady), 1);
    stepCycle();
    applyStimulus(0, 9'h000, 0, 0, 0, 4'd0, 8'h00);
    #1;
    checkVal("branch pulse ends", int'(redirectValid), 0);
    checkVal("branch shadow dropped", int'(aluValid), 0);
    checkVal("branch back to run", int'(inReady), 1);
    stepCycle();
    applyStimulus(1, 9'h003, 0, 0, 0, 4'd0, 8'h00);
    stepCycle();
    applyStimulus(0, 9'h000, 1, 0, 0, 4'd0, 8'h00);
    #1 checkVal("post branch issue", int'(aluValid), 1);
    stepCycle();
    applyStimulus(0, 9'h000, 0, 0, 1, 4'd0, 8'h11);
    stepCycle();

    // Downstream backpressure for three cycles
    applyStimulus(1, 9'h105, 0, 0, 0, 4'd0, 8'h00);
    stepCycle();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 9'h003, 0, 0, 0, 4'd0, 8'h00);
      #1;
      checkVal($sformatf("hold%0d in_ready", k), int'(inReady), 0);
      checkVal($sformatf("hold%0d alu_valid", k), int'(aluValid), 1);
      checkVal($sformatf("hold%0d op", k), int'(aluOp), 5'h10);
      checkVal($sformatf("hold%0d in_one", k), int'(aluInOne), 8'h11);
      checkVal($sformatf("hold%0d in_two", k), int'(aluInTwo), 8'h05);
      stepCycle();
    end
    applyStimulus(0, 9'h000, 1, 0, 0, 4'd0, 8'h00);
    stepCycle();
    applyStimulus(0, 9'h000, 0, 0, 0, 4'd0, 8'h00);
    #1;
    checkVal("hold issued", int'(aluValid), 0);
    checkVal("hold count one", int'(inReady), 0);
    stepCycle();
    applyStimulus(0, 9'h000, 0, 0, 1, 4'd0, 8'h11);
    stepCycle();

    // R0 writeback with nothing in flight
    applyStimulus(0, 9'h000, 0, 0, 1, 4'd0, 8'h5C);
    #1 checkVal("underflow before", int'(errUnderflow), 0);
    stepCycle();
    applyStimulus(0, 9'h000, 0, 0, 0, 4'd0, 8'h00);
    #1;
    checkVal("underflow set", int'(errUnderflow), 1);
    checkVal("underflow count zero", int'(inReady), 1);
    stepCycle();
    applyStimulus(1, 9'h000, 0, 0, 0, 4'd0, 8'h00);
    stepCycle();
    applyStimulus(0, 9'h000, 1, 0, 0, 4'd0, 8'h00);
    #1;
    checkVal("underflow r0 one", int'(aluInOne), 8'h5C);
    checkVal("underflow r0 two", int'(aluInTwo), 8'h5C);
    stepCycle();
    applyStimulus(0, 9'h000, 0, 0, 1, 4'd0, 8'h5C);
    stepCycle();
    applyStimulus(0, 9'h000, 0, 0, 0, 4'd0, 8'h00);
    #1 checkVal("underflow sticky", int'(errUnderflow), 1);
    stepCycle();

    // Reset while squashing with a live op in the issue register
    applyStimulus(1, 9'h1BE, 0, 0, 0, 4'd0, 8'h00);
    stepCycle();
    applyStimulus(1, 9'h003, 1, 1, 0, 4'd0, 8'h00);
    #1 checkVal("squash setup in_ready", int'(inReady), 1);
    stepCycle();
    applyStimulus(0, 9'h000, 0, 0, 0, 4'd0, 8'h00);
    #1;
    checkVal("squash setup alu_valid", int'(aluValid), 1);
    checkVal("squash setup redirect", int'(redirectValid), 1);
    rst_n = 1'b0;
    #1;
    checkVal("async reset alu_valid", int'(aluValid), 0);
    checkVal("async reset op", int'(aluOp), 0);
    checkVal("async reset in_one", int'(aluInOne), 0);
    checkVal("async reset in_two", int'(aluInTwo), 0);
    checkVal("async reset redirect_valid", int'(redirectValid), 0);
    checkVal("async reset redirect_off", int'(redirectOff), 0);
    checkVal("async reset err", int'(errUnderflow), 0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 9'h105, 0, 0, 0, 4'd0, 8'h00);
    stepCycle();
    applyStimulus(0, 9'h000, 1, 0, 0, 4'd0, 8'h00);
    #1;
    checkVal("after reset alu_valid", int'(aluValid), 1);
    checkVal("after reset op", int'(aluOp), 5'h10);
    checkVal("after reset in_one", int'(aluInOne), 0);
    checkVal("after reset in_two", int'(aluInTwo), 8'h05);
    stepCycle();
    applyStimulus(0, 9'h000, 0, 0, 1, 4'd0, 8'h00);
    stepCycle();

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    9'($urandom_range(0, 511)),
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 2) == 0,
                    ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                    8'($urandom_range(0, 255)));
      stepCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
